// File: rtl/rsp_bus_tx.sv
// rsp_bus_tx: return-path transmitter for the command handshake synchroniser
// pair, living entirely in the dst_clk domain.
//
// Response words arrive on a valid/ready port and are buffered in a small
// FIFO. Each word is then sent to the src_clk domain over a four-phase
// req/ack level handshake. xfer_data is held stable for the whole transfer.
// A sticky flag reports an ack phase that waited too long.
//
// Ports:
//   dst_clk, dst_rst      block clock; asynchronous active-low reset
//   in_data/in_valid      response word from local logic
//   in_ready              FIFO can accept (!full)
//   xfer_req/xfer_data    registered four-phase request and word under transfer
//   xfer_ack              four-phase ack from src domain (asynchronous)
//   xfer_done             one-cycle pulse when a transfer completes
//   busy                  FSM not idle or FIFO non-empty
//   fifo_level            current FIFO occupancy
//   err_timeout, err_clr  sticky ack-timeout flag and its clear
module rsp_bus_tx #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 3,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                          dst_clk,
    input  logic                          dst_rst,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          xfer_req,
    output logic [DATA_WIDTH-1:0]         xfer_data,
    input  logic                          xfer_ack,
    output logic                          xfer_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_timeout,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // The counter stops one past the trip point so the flag sets only once
    // per phase, letting err_clr stick while the FSM keeps waiting.
    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;
    localparam bit TO_EN = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            level;
    logic                   full, empty, push, pop;

    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    state_t                 state, state_nxt;
    logic                   req_nxt, done_nxt;
    logic [CW-1:0]          cnt;

    // ---- FIFO: push from the port, pop only from the FSM ----
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign push     = in_valid && !full;
    assign in_ready = !full;
    assign fifo_level = level;

    always_ff @(posedge dst_clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // ---- ack synchroniser: the only sampler of xfer_ack ----
    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) ack_sync <= '0;
        else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // ---- handshake FSM ----
    always_comb begin
        state_nxt = state;
        req_nxt   = xfer_req;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                req_nxt = 1'b0;
                // A still-high ack belongs to the previous transfer; wait it out.
                if (!empty && !ack_s) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    pop       = 1'b1;
                end
            end
            REQ: begin
                req_nxt = 1'b1;
                if (ack_s) begin
                    state_nxt = REL;
                    req_nxt   = 1'b0;
                end
            end
            REL: begin
                req_nxt = 1'b0;
                if (!ack_s) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) begin
            state     <= IDLE;
            xfer_req  <= 1'b0;
            xfer_done <= 1'b0;
            xfer_data <= '0;
        end else begin
            state     <= state_nxt;
            xfer_req  <= req_nxt;
            xfer_done <= done_nxt;
            if (pop) xfer_data <= mem[rd_ptr];
        end
    end

    // ---- ack timeout ----
    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state_nxt != state)
                cnt <= '0;
            else if (state != IDLE && cnt <= TMAX)
                cnt <= cnt + CW'(1);
            // Setting takes priority over a simultaneous clear.
            if (TO_EN && state != IDLE && cnt == TMAX)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_rsp_bus_tx.sv
module tb_rsp_bus_tx;

    localparam int DW = 16;
    localparam int FD = 4;
    localparam int SS = 3;
    localparam int AT = 16;

    logic          dst_clk = 1'b1;
    logic          src_clk = 1'b0;
    logic          dst_rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          xfer_req;
    logic [DW-1:0] xfer_data;
    logic          xfer_ack;
    logic          xfer_done;
    logic          busy;
    logic [2:0]    fifo_level;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    // remote ack model: follows xfer_req after 2 src_clk edges in auto mode
    logic ack_auto  = 1'b1;
    logic ack_man   = 1'b0;
    logic ack_model = 1'b0;
    logic req_seen  = 1'b0;
    assign xfer_ack = ack_auto ? ack_model : ack_man;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic saw_full = 1'b0;
    logic bad_ready = 1'b0;

    rsp_bus_tx #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .SYNC_STAGES(SS), .ACK_TIMEOUT(AT)
    ) dut (
        .dst_clk(dst_clk), .dst_rst(dst_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack(xfer_ack),
        .xfer_done(xfer_done), .busy(busy), .fifo_level(fifo_level),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    // dst posedges at even ns, src posedges at odd ns: never coincident
    initial forever #5 dst_clk = ~dst_clk;
    initial begin
        #2;
        forever #7 src_clk = ~src_clk;
    end

    initial forever begin
        @(posedge src_clk);
        ack_model = req_seen;
        req_seen  = xfer_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dst_clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (fifo_level == FD && !in_ready) saw_full = 1'b1;
            if (in_ready !== (fifo_level != FD)) bad_ready = 1'b1;
            if (in_ready) begin
                exp_q.push_back(d);
                tick();
                return;
            end
            tick();
        end
        check("push_accept", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_req(input int bound);
        for (int i = 0; i < bound && !xfer_req; i++) tick();
        check("req_rise", {31'd0, xfer_req}, 32'd1);
    endtask

    task automatic wait_done(input int target, input int bound);
        for (int i = 0; i < bound && done_cnt < target; i++) tick();
        check("done_count", done_cnt, target);
    endtask

    // monitor: pops expected word at each request rise, checks stability to done
    initial begin
        logic          prev_req;
        logic          in_xfer;
        logic          stable;
        logic [DW-1:0] cap;
        logic [DW-1:0] exp;
        prev_req = 1'b0;
        in_xfer  = 1'b0;
        stable   = 1'b1;
        cap      = '0;
        forever begin
            tick();
            if (!dst_rst) begin
                prev_req = 1'b0;
                in_xfer  = 1'b0;
            end else begin
                if (xfer_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", {16'd0, xfer_data}, 32'hFFFF_FFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        check("xfer_data", {16'd0, xfer_data}, {16'd0, exp});
                    end
                    cap     = xfer_data;
                    in_xfer = 1'b1;
                    stable  = 1'b1;
                end else if (in_xfer && xfer_data !== cap) begin
                    stable = 1'b0;
                end
                if (xfer_done) begin
                    done_cnt++;
                    check("done_in_xfer", {31'd0, in_xfer}, 32'd1);
                    check("data_stable", {31'd0, stable}, 32'd1);
                    in_xfer = 1'b0;
                end
                prev_req = xfer_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        int done_before;
        // reset values
        #1 dst_rst = 1'b0;
        #2;
        check("rst_req", {31'd0, xfer_req}, 32'd0);
        check("rst_data", {16'd0, xfer_data}, 32'd0);
        check("rst_done", {31'd0, xfer_done}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #20 dst_rst = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // single word
        push(16'hA5C3);
        in_valid = 1'b0;
        check("single_level", {29'd0, fifo_level}, 32'd1);
        check("single_req_pre", {31'd0, xfer_req}, 32'd0);
        tick();
        check("single_req", {31'd0, xfer_req}, 32'd1);
        check("single_data", {16'd0, xfer_data}, 32'hA5C3);
        wait_done(1, 100);
        tick();
        check("single_busy", {31'd0, busy}, 32'd0);

        // burst of 6 through a 4-deep FIFO
        tgt = done_cnt + 6;
        for (int i = 1; i <= 6; i++) push(DW'(i));
        in_valid = 1'b0;
        check("burst_full_seen", {31'd0, saw_full}, 32'd1);
        check("burst_ready_flag", {31'd0, bad_ready}, 32'd0);
        wait_done(tgt, 400);
        check("burst_drained", exp_q.size(), 0);
        check("burst_no_err", {31'd0, err_timeout}, 32'd0);

        // stale ack blocks the next request
        ack_auto = 1'b0;
        ack_man  = 1'b1;
        repeat (5) tick();
        push(16'h1234);
        in_valid = 1'b0;
        repeat (8) tick();
        check("stale_req", {31'd0, xfer_req}, 32'd0);
        check("stale_data", {16'd0, xfer_data}, 32'h0006);
        check("stale_level", {29'd0, fifo_level}, 32'd1);
        ack_man = 1'b0;
        tick();
        tick();
        tick();
        check("stale_req_hold", {31'd0, xfer_req}, 32'd0);
        tick();
        check("stale_req_rise", {31'd0, xfer_req}, 32'd1);
        tgt = done_cnt + 1;
        ack_auto = 1'b1;
        wait_done(tgt, 100);

        // timeout: ack withheld during REQ
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        push(16'hBEEF);
        in_valid = 1'b0;
        wait_req(20);
        repeat (15) tick();
        check("to_err_before", {31'd0, err_timeout}, 32'd0);
        tick();
        check("to_err_set", {31'd0, err_timeout}, 32'd1);
        check("to_req_held", {31'd0, xfer_req}, 32'd1);
        tgt = done_cnt + 1;
        ack_auto = 1'b1;
        wait_done(tgt, 100);
        check("to_err_sticky", {31'd0, err_timeout}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_clr", {31'd0, err_timeout}, 32'd0);

        // set beats a simultaneous clear
        ack_auto = 1'b0;
        err_clr  = 1'b1;
        push(16'hC0DE);
        in_valid = 1'b0;
        wait_req(20);
        repeat (15) tick();
        tick();
        check("setwins_set", {31'd0, err_timeout}, 32'd1);
        tick();
        check("setwins_clr", {31'd0, err_timeout}, 32'd0);
        err_clr = 1'b0;
        tgt = done_cnt + 1;
        ack_auto = 1'b1;
        wait_done(tgt, 100);

        // reset in REQ with 2 words buffered
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        push(16'h0A01);
        push(16'h0A02);
        push(16'h0A03);
        in_valid = 1'b0;
        check("mrst_pre_level", {29'd0, fifo_level}, 32'd2);
        check("mrst_pre_req", {31'd0, xfer_req}, 32'd1);
        done_before = done_cnt;
        #3 dst_rst = 1'b0;
        #1;
        check("mrst_req", {31'd0, xfer_req}, 32'd0);
        check("mrst_level", {29'd0, fifo_level}, 32'd0);
        check("mrst_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        #20 dst_rst = 1'b1;
        repeat (10) tick();
        check("mrst_no_done", done_cnt, done_before);
        check("mrst_req_after", {31'd0, xfer_req}, 32'd0);

        // simultaneous push and pop at level 2
        ack_man = 1'b1;
        repeat (5) tick();
        push(16'h0D01);
        push(16'h0D02);
        in_valid = 1'b0;
        check("pp_pre_level", {29'd0, fifo_level}, 32'd2);
        check("pp_pre_req", {31'd0, xfer_req}, 32'd0);
        ack_man = 1'b0;
        tick();
        tick();
        tick();
        in_data  = 16'h0D03;
        in_valid = 1'b1;
        exp_q.push_back(16'h0D03);
        tick();
        in_valid = 1'b0;
        check("pp_level", {29'd0, fifo_level}, 32'd2);
        check("pp_req", {31'd0, xfer_req}, 32'd1);
        tgt = done_cnt + 3;
        ack_auto = 1'b1;
        wait_done(tgt, 300);
        check("pp_drained", exp_q.size(), 0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
